dma_peripheral_endpoint: RTL
============================

DMA_PERIPHERAL_ENDPOINT -- requirements
Module: dma_peripheral_endpoint

Interface
REQ-001 Parameter DEPTH, default 4, entries per FIFO; power of two, 2 to 16.
REQ-002 Parameter WIDTH, default 8, data bus width in bits.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  permits new DMA requests.
REQ-006 dir  in  1  transfer direction: 0 = peripheral-to-memory (IOR); 1 = memory-to-peripheral (IOW).
REQ-007 DREQ  out  1  DMA request to the controller, registered.
REQ-008 DACK  in  1  DMA acknowledge for this channel, active-high.
REQ-009 IOR_N  in  1  I/O read strobe; active only when sampled 1'b0; 1, X and Z are inactive.
REQ-010 IOW_N  in  1  I/O write strobe; same activity rule as IOR_N.
REQ-011 EOP_N  in  1  end-of-process; active only when sampled 1'b0.
REQ-012 DB_IN  in  WIDTH  data bus input, captured on IOW.
REQ-013 DB_OUT  out  WIDTH  data bus output, driven on IOR.
REQ-014 DB_OE  out  1  data bus output enable.
REQ-015 wr_valid/wr_data/wr_ready  in/in/out  1/WIDTH/1  local push into the TX FIFO.
REQ-016 rd_valid/rd_data/rd_ready  out/out/in  1/WIDTH/1  local pop from the RX FIFO.
REQ-017 xfer_count  out  16  count of completed bus transfers.
REQ-018 eop_flag  out  1  sticky: EOP was received.
REQ-019 clr_eop  in  1  pulse that clears eop_flag.
REQ-020 err  out  1  sticky protocol-error flag; cleared only by RESET.

Function
REQ-021 FIFOs: TX FIFO is local-to-bus; RX FIFO is bus-to-local. Each is DEPTH deep, first-in first-out, with pointers that wrap modulo DEPTH.
REQ-022 wr_ready = TX not full; rd_valid = RX not empty; rd_data = RX head.
REQ-023 A push and a pop in the same cycle on the same FIFO both take effect and leave the occupancy unchanged.
REQ-024 The state machine has four states: IDLE, REQ, ACK, DONE.
REQ-025 IDLE->REQ when the request condition is true: enable=1, eop_flag=0, and either (dir=0 and TX not empty) or (dir=1 and RX not full). dir is latched into dir_q on this transition.
REQ-026 DREQ=1 in REQ and ACK, and 0 in IDLE and DONE, so it rises one cycle after the request condition is seen.
REQ-027 REQ->ACK when DACK=1.
REQ-028 ACK, dir_q=0, DACK=1, IOR_N active:
  - DB_OE=1 and DB_OUT = TX head, combinationally in that cycle;
  - TX pops at the clock edge;
  - xfer_count increments;
  - next state is DONE.
REQ-029 ACK, dir_q=1, DACK=1, IOW_N active:
  - DB_IN is pushed into RX at the clock edge;
  - xfer_count increments;
  - next state is DONE.
REQ-030 ACK with DACK=0 and no strobe returns to REQ; no transfer occurs.
REQ-031 DONE->IDLE unconditionally, so DREQ is low for at least one cycle between transfers.
REQ-032 At most one transfer is made per ACK visit, even if the strobe stays low for several cycles.
REQ-033 Strobes are ignored in every state other than ACK, and whenever DACK=0.
REQ-034 A strobe of the wrong direction in ACK (IOW with dir_q=0, or IOR with dir_q=1) sets err and causes no transfer; the state is held.
REQ-035 IOR_N and IOW_N both active in ACK sets err; no transfer occurs and the state goes to DONE.
REQ-036 EOP_N active in REQ or ACK sets eop_flag and forces DONE. If EOP coincides with a valid strobe in ACK, the transfer completes first.
REQ-037 While eop_flag=1, IDLE never advances. When clr_eop and EOP_N are active in the same cycle, eop_flag is set (set wins).
REQ-038 DB_OE=0 and DB_OUT=0 whenever no IOR transfer is in progress.
REQ-039 xfer_count wraps from 16'hFFFF to 0.
REQ-040 A change on dir outside IDLE has no effect until the next IDLE->REQ transition.

Reset
REQ-041 On RESET=1 at a rising edge:
  - state=IDLE; DREQ=0; DB_OE=0; DB_OUT=0;
  - both FIFOs empty; wr_ready=1; rd_valid=0;
  - xfer_count=0; eop_flag=0; err=0.
REQ-042 RESET during REQ or ACK aborts the transfer: no pop, no push, no count change; DREQ=0 on the following cycle.

Verification
REQ-043 dir=0, push 8'hA5, enable=1 -> DREQ=1 two cycles later; DACK=1 then IOR_N=0 for one cycle -> DB_OUT=8'hA5 with DB_OE=1; then DREQ=0 for one cycle, TX empty, xfer_count=1.
REQ-044 dir=1, RX empty, DACK=1 with IOW_N=0 and DB_IN=8'h3C, repeated DEPTH times -> RX full, DREQ stays 0; rd_ready=1 pops 8'h3C in order; DREQ reasserts after the first pop.
REQ-045 IOR_N held low for 3 cycles in ACK -> exactly one pop and xfer_count increments by 1.
REQ-046 EOP_N=0 while in REQ -> eop_flag=1, DREQ=0 next cycle, no new request; clr_eop pulse -> requests resume.
REQ-047 IOW_N=0 in ACK with dir_q=0 -> err=1, FIFOs unchanged; RESET -> every output at its reset value.

Source files
------------

// File: rtl/dma_peripheral_endpoint.sv
// DMA peripheral endpoint: one 8237-style DMA channel handshake (DREQ/DACK/IOR/IOW/EOP)
// with a local-to-bus TX FIFO and a bus-to-local RX FIFO, transfer counter and status flags.
module dma_peripheral_endpoint #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             dir,
  output logic             DREQ,
  input  logic             DACK,
  input  logic             IOR_N,
  input  logic             IOW_N,
  input  logic             EOP_N,
  input  logic [WIDTH-1:0] DB_IN,
  output logic [WIDTH-1:0] DB_OUT,
  output logic             DB_OE,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic [15:0]      xfer_count,
  output logic             eop_flag,
  input  logic             clr_eop,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_r, state_next_s;
  logic   dir_q_r;

  logic [WIDTH-1:0] tx_mem_r [DEPTH];
  logic [AW-1:0]    tx_wptr_r, tx_rptr_r;
  logic [CW-1:0]    tx_cnt_r;
  logic [WIDTH-1:0] rx_mem_r [DEPTH];
  logic [AW-1:0]    rx_wptr_r, rx_rptr_r;
  logic [CW-1:0]    rx_cnt_r;

  logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic ior_act_s, iow_act_s, eop_act_s, dack_act_s;
  logic good_rd_s, good_wr_s, both_s, wrong_s;
  logic req_cond_s, xfer_s, err_set_s, eop_set_s, dir_latch_s;

  // Strobes count as active only on a clean 0; X/Z on the bus is treated as idle.
  assign ior_act_s  = (IOR_N === 1'b0);
  assign iow_act_s  = (IOW_N === 1'b0);
  assign eop_act_s  = (EOP_N === 1'b0);
  assign dack_act_s = (DACK === 1'b1);

  assign tx_empty_s = (tx_cnt_r == {CW{1'b0}});
  assign tx_full_s  = (tx_cnt_r == DEPTH_C);
  assign rx_empty_s = (rx_cnt_r == {CW{1'b0}});
  assign rx_full_s  = (rx_cnt_r == DEPTH_C);

  assign wr_ready  = ~tx_full_s;
  assign rd_valid  = ~rx_empty_s;
  assign rd_data   = rx_mem_r[rx_rptr_r];
  assign tx_push_s = wr_valid & ~tx_full_s;
  assign rx_pop_s  = rd_ready & ~rx_empty_s;

  assign good_rd_s = dack_act_s & ior_act_s & ~iow_act_s & ~dir_q_r;
  assign good_wr_s = dack_act_s & iow_act_s & ~ior_act_s & dir_q_r;
  assign both_s    = dack_act_s & ior_act_s & iow_act_s;
  assign wrong_s   = dack_act_s & ((ior_act_s & ~iow_act_s & dir_q_r) |
                                   (iow_act_s & ~ior_act_s & ~dir_q_r));

  assign req_cond_s = enable & ~eop_flag & (dir ? ~rx_full_s : ~tx_empty_s);

  // Next-state and per-cycle transfer decisions of the handshake FSM.
  always_comb begin
    state_next_s = state_r;
    tx_pop_s     = 1'b0;
    rx_push_s    = 1'b0;
    xfer_s       = 1'b0;
    err_set_s    = 1'b0;
    eop_set_s    = 1'b0;
    dir_latch_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_cond_s) begin
          state_next_s = S_REQ;
          dir_latch_s  = 1'b1;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (eop_act_s) begin
          eop_set_s    = 1'b1;
          state_next_s = S_DONE;
        end else if (dack_act_s) begin
          state_next_s = S_ACK;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_ACK: begin
        tx_pop_s  = good_rd_s & ~tx_empty_s;
        rx_push_s = good_wr_s & ~rx_full_s;
        xfer_s    = tx_pop_s | rx_push_s;
        err_set_s = both_s | wrong_s;
        eop_set_s = eop_act_s;
        // A completed transfer always leaves ACK, so one ACK visit moves at most one word.
        if (eop_act_s || xfer_s || both_s) begin
          state_next_s = S_DONE;
        end else if (!dack_act_s) begin
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_ACK;
        end
      end
      S_DONE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Bus drive: only during an IOR transfer cycle, otherwise the bus output is parked at zero.
  always_comb begin
    if (tx_pop_s) begin
      DB_OE  = 1'b1;
      DB_OUT = tx_mem_r[tx_rptr_r];
    end else begin
      DB_OE  = 1'b0;
      DB_OUT = {WIDTH{1'b0}};
    end
  end

  // FSM state, latched direction, registered DREQ, counter and sticky flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= S_IDLE;
      dir_q_r    <= 1'b0;
      DREQ       <= 1'b0;
      xfer_count <= 16'd0;
      eop_flag   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (dir_latch_s) dir_q_r <= dir;
      DREQ <= (state_next_s == S_REQ) || (state_next_s == S_ACK);
      if (xfer_s) xfer_count <= xfer_count + 16'd1;
      // Set has priority over clear so an EOP is never lost.
      if (eop_set_s) eop_flag <= 1'b1;
      else if (clr_eop) eop_flag <= 1'b0;
      if (err_set_s) err <= 1'b1;
    end
  end

  // TX FIFO: pushed by the local side, popped by IOR transfers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_wptr_r <= {AW{1'b0}};
      tx_rptr_r <= {AW{1'b0}};
      tx_cnt_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) tx_mem_r[i] <= {WIDTH{1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wptr_r] <= wr_data;
        tx_wptr_r           <= tx_wptr_r + PTR_ONE;
      end
      if (tx_pop_s) tx_rptr_r <= tx_rptr_r + PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + CNT_ONE;
        2'b01:   tx_cnt_r <= tx_cnt_r - CNT_ONE;
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // RX FIFO: pushed by IOW transfers, popped by the local side.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_wptr_r <= {AW{1'b0}};
      rx_rptr_r <= {AW{1'b0}};
      rx_cnt_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) rx_mem_r[i] <= {WIDTH{1'b0}};
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wptr_r] <= DB_IN;
        rx_wptr_r           <= rx_wptr_r + PTR_ONE;
      end
      if (rx_pop_s) rx_rptr_r <= rx_rptr_r + PTR_ONE;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + CNT_ONE;
        2'b01:   rx_cnt_r <= rx_cnt_r - CNT_ONE;
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

endmodule
